// File: rtl/maze_ctrl.sv
// Maze game controller: level select, edge-detected buttons, one move per frame, wall/bounds checks, win detection.
// Optional MOVE_COUNT_EN adds a saturating 10-bit accepted-move counter on o_MoveCnt.
module maze_ctrl #(
   parameter logic [5:0] START_X = 6'd1,
   parameter logic [4:0] START_Y = 5'd1
)(
   input  logic          i_Clk,
   input  logic          i_Rst,
   input  logic          i_Start,
   input  logic [1:0]    i_LevelSel,
   input  logic [3:0]    i_Btn,
   input  logic          i_fDrawDone,
   input  logic [1199:0] i_Map,
   output logic [1:0]    o_Level,
   output logic [5:0]    o_PlayerPos_X,
   output logic [4:0]    o_PlayerPos_Y,
   output logic [5:0]    o_GoalPos_X,
   output logic [4:0]    o_GoalPos_Y,
   output logic          o_fWin,
   output logic [2:0]    o_State
`ifdef MOVE_COUNT_EN
   ,output logic [9:0]   o_MoveCnt
`endif
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      PLAY  = 3'd2,
      CHECK = 3'd3,
      WIN   = 3'd4
   } state_t;

   localparam logic [1:0] DIR_UP    = 2'd0;
   localparam logic [1:0] DIR_DOWN  = 2'd1;
   localparam logic [1:0] DIR_LEFT  = 2'd2;
   localparam logic [1:0] DIR_RIGHT = 2'd3;

   state_t      stateR, stateS;
   logic        startPrevR;
   logic [3:0]  btnPrevR;
   logic        pendValidR;
   logic [1:0]  pendDirR;

   logic        startPressS;
   logic [3:0]  btnPressS;
   logic        anyPressS;
   logic [1:0]  pressDirS;
   logic [5:0]  gridW;
   logic [4:0]  gridH;
   logic [5:0]  tgtXS, newXS;
   logic [4:0]  tgtYS, newYS;
   logic        inBndS, wallS, moveOkS;
   logic [10:0] linIdxS, mapIdxS;

   assign startPressS = i_Start & ~startPrevR;
   assign btnPressS   = i_Btn & ~btnPrevR;
   assign anyPressS   = |btnPressS;
   assign o_State     = stateR;

   // Grid size of the active level.
   always_comb begin
      gridW = 6'd40;
      gridH = 5'd30;
      case (o_Level)
         2'b01:   begin gridW = 6'd16; gridH = 5'd12; end
         2'b10:   begin gridW = 6'd32; gridH = 5'd24; end
         2'b11:   begin gridW = 6'd40; gridH = 5'd30; end
         default: begin gridW = 6'd40; gridH = 5'd30; end
      endcase
   end

   // Fixed priority up > down > left > right among simultaneous presses.
   always_comb begin
      pressDirS = DIR_RIGHT;
      if (btnPressS[3])      pressDirS = DIR_UP;
      else if (btnPressS[2]) pressDirS = DIR_DOWN;
      else if (btnPressS[1]) pressDirS = DIR_LEFT;
      else                   pressDirS = DIR_RIGHT;
   end

   // Target cell, bounds and wall lookup; an out-of-bounds target keeps the current cell.
   always_comb begin
      tgtXS  = o_PlayerPos_X;
      tgtYS  = o_PlayerPos_Y;
      inBndS = 1'b1;
      case (pendDirR)
         DIR_UP: begin
            if (o_PlayerPos_Y == 5'd0) inBndS = 1'b0;
            else                       tgtYS  = o_PlayerPos_Y - 5'd1;
         end
         DIR_DOWN: begin
            if (o_PlayerPos_Y >= gridH - 5'd1) inBndS = 1'b0;
            else                               tgtYS  = o_PlayerPos_Y + 5'd1;
         end
         DIR_LEFT: begin
            if (o_PlayerPos_X == 6'd0) inBndS = 1'b0;
            else                       tgtXS  = o_PlayerPos_X - 6'd1;
         end
         DIR_RIGHT: begin
            if (o_PlayerPos_X >= gridW - 6'd1) inBndS = 1'b0;
            else                               tgtXS  = o_PlayerPos_X + 6'd1;
         end
         default: inBndS = 1'b0;
      endcase
      linIdxS = ({6'd0, tgtYS} * 11'd40) + {5'd0, tgtXS};
      mapIdxS = 11'd0;
      wallS   = 1'b1;
      if (linIdxS <= 11'd1199) begin
         mapIdxS = 11'd1199 - linIdxS;
         wallS   = i_Map[mapIdxS];
      end else begin
         mapIdxS = 11'd0;
         wallS   = 1'b1;
      end
      moveOkS = pendValidR & inBndS & ~wallS;
      if (moveOkS) begin
         newXS = tgtXS;
         newYS = tgtYS;
      end else begin
         newXS = o_PlayerPos_X;
         newYS = o_PlayerPos_Y;
      end
   end

   // Next-state logic.
   always_comb begin
      stateS = stateR;
      case (stateR)
         IDLE: begin
            if (startPressS && (i_LevelSel != 2'b00)) stateS = LOAD;
            else                                      stateS = IDLE;
         end
         LOAD: stateS = PLAY;
         PLAY: begin
            if (startPressS)                     stateS = IDLE;
            else if (i_fDrawDone && pendValidR)  stateS = CHECK;
            else                                 stateS = PLAY;
         end
         CHECK: begin
            if ((newXS == o_GoalPos_X) && (newYS == o_GoalPos_Y)) stateS = WIN;
            else                                                  stateS = PLAY;
         end
         WIN: begin
            if (startPressS) stateS = IDLE;
            else             stateS = WIN;
         end
         default: stateS = IDLE;
      endcase
   end

   // State, edge history, pending move, level and positions.
   always_ff @(posedge i_Clk or negedge i_Rst) begin
      if (!i_Rst) begin
         stateR        <= IDLE;
         startPrevR    <= 1'b0;
         btnPrevR      <= 4'b0000;
         pendValidR    <= 1'b0;
         pendDirR      <= DIR_UP;
         o_Level       <= 2'b00;
         o_PlayerPos_X <= START_X;
         o_PlayerPos_Y <= START_Y;
         o_GoalPos_X   <= 6'd0;
         o_GoalPos_Y   <= 5'd0;
         o_fWin        <= 1'b0;
      end else begin
         stateR     <= stateS;
         startPrevR <= i_Start;
         btnPrevR   <= i_Btn;
         o_fWin     <= (stateS == WIN);
         case (stateR)
            IDLE: begin
               pendValidR <= 1'b0;
               if (stateS == LOAD) o_Level <= i_LevelSel;
               else                o_Level <= o_Level;
            end
            LOAD: begin
               o_PlayerPos_X <= START_X;
               o_PlayerPos_Y <= START_Y;
               o_GoalPos_X   <= gridW - 6'd2;
               o_GoalPos_Y   <= gridH - 5'd2;
               pendValidR    <= 1'b0;
            end
            PLAY: begin
               if (stateS == IDLE) begin
                  o_Level    <= 2'b00;
                  pendValidR <= 1'b0;
               end else if (!pendValidR && anyPressS) begin
                  pendValidR <= 1'b1;
                  pendDirR   <= pressDirS;
               end else begin
                  pendValidR <= pendValidR;
               end
            end
            CHECK: begin
               o_PlayerPos_X <= newXS;
               o_PlayerPos_Y <= newYS;
               pendValidR    <= 1'b0;
            end
            WIN: begin
               if (stateS == IDLE) o_Level <= 2'b00;
               else                o_Level <= o_Level;
            end
            default: pendValidR <= 1'b0;
         endcase
      end
   end

`ifdef MOVE_COUNT_EN
   // Accepted-move counter, saturating at 1023.
   always_ff @(posedge i_Clk or negedge i_Rst) begin
      if (!i_Rst) begin
         o_MoveCnt <= 10'd0;
      end else begin
         case (stateR)
            LOAD:  o_MoveCnt <= 10'd0;
            CHECK: begin
               if (moveOkS && (o_MoveCnt != 10'd1023)) o_MoveCnt <= o_MoveCnt + 10'd1;
               else                                    o_MoveCnt <= o_MoveCnt;
            end
            default: o_MoveCnt <= o_MoveCnt;
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_maze_ctrl.sv
// Directed bench for maze_ctrl: a per-cycle vector table plus hand-written wall, boundary, win and reset sequences.
module tb_maze_ctrl;

   localparam int halfClk = 5;

   logic          i_Clk = 1'b0;
   logic          i_Rst = 1'b0;
   logic          i_Start = 1'b0;
   logic [1:0]    i_LevelSel = 2'b00;
   logic [3:0]    i_Btn = 4'b0000;
   logic          i_fDrawDone = 1'b0;
   logic [1199:0] i_Map = '0;
   logic [1:0]    o_Level;
   logic [5:0]    o_PlayerPos_X;
   logic [4:0]    o_PlayerPos_Y;
   logic [5:0]    o_GoalPos_X;
   logic [4:0]    o_GoalPos_Y;
   logic          o_fWin;
   logic [2:0]    o_State;
`ifdef MOVE_COUNT_EN
   logic [9:0]    o_MoveCnt;
`endif

   int nVec = 0;
   int nMiss = 0;

   maze_ctrl dut (
      .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Start(i_Start), .i_LevelSel(i_LevelSel),
      .i_Btn(i_Btn), .i_fDrawDone(i_fDrawDone), .i_Map(i_Map),
      .o_Level(o_Level), .o_PlayerPos_X(o_PlayerPos_X), .o_PlayerPos_Y(o_PlayerPos_Y),
      .o_GoalPos_X(o_GoalPos_X), .o_GoalPos_Y(o_GoalPos_Y), .o_fWin(o_fWin),
      .o_State(o_State)
`ifdef MOVE_COUNT_EN
      , .o_MoveCnt(o_MoveCnt)
`endif
   );

   always #halfClk i_Clk = ~i_Clk;

   typedef struct {
      logic       start;
      logic [1:0] sel;
      logic [3:0] btn;
      logic       dd;
      int         st;
      int         lvl;
      int         px;
      int         py;
      int         gx;
      int         gy;
      int         win;
   } vec_t;

   vec_t tbl[22];

   task automatic chk(input string name, input int act, input int exp);
      nVec++;
      if (act != exp) begin
         nMiss++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_Clk);
      #1;
   endtask

   task automatic chkPos(input string name, input int x, input int y);
      chk({name, " x"}, int'(o_PlayerPos_X), x);
      chk({name, " y"}, int'(o_PlayerPos_Y), y);
   endtask

   // Press a direction, pulse end-of-frame, then let CHECK resolve.
   task automatic move(input logic [3:0] b);
      i_Btn = b;
      tick();
      i_Btn = 4'b0000;
      i_fDrawDone = 1'b1;
      tick();
      i_fDrawDone = 1'b0;
      tick();
   endtask

   task automatic pressStart();
      i_Start = 1'b1;
      tick();
      i_Start = 1'b0;
      tick();
   endtask

   // From PLAY or WIN: abandon to IDLE, then start a fresh game at the given level.
   task automatic newGame(input logic [1:0] sel);
      pressStart();
      i_LevelSel = sel;
      pressStart();
   endtask

   initial begin
      //             start sel    btn     dd    st lvl px py gx  gy win
      tbl[0]  = '{1'b0, 2'b01, 4'b0000, 1'b0, 0, 0, 1, 1, 0,  0,  0};
      tbl[1]  = '{1'b1, 2'b01, 4'b0000, 1'b0, 1, 1, 1, 1, 0,  0,  0};
      tbl[2]  = '{1'b1, 2'b01, 4'b0000, 1'b0, 2, 1, 1, 1, 14, 10, 0};
      tbl[3]  = '{1'b0, 2'b01, 4'b0001, 1'b0, 2, 1, 1, 1, 14, 10, 0};
      tbl[4]  = '{1'b0, 2'b01, 4'b0001, 1'b0, 2, 1, 1, 1, 14, 10, 0};
      tbl[5]  = '{1'b0, 2'b01, 4'b0000, 1'b0, 2, 1, 1, 1, 14, 10, 0};
      tbl[6]  = '{1'b0, 2'b01, 4'b1000, 1'b0, 2, 1, 1, 1, 14, 10, 0};
      tbl[7]  = '{1'b0, 2'b01, 4'b0000, 1'b1, 3, 1, 1, 1, 14, 10, 0};
      tbl[8]  = '{1'b0, 2'b01, 4'b0000, 1'b0, 2, 1, 2, 1, 14, 10, 0};
      tbl[9]  = '{1'b0, 2'b01, 4'b0000, 1'b1, 2, 1, 2, 1, 14, 10, 0};
      tbl[10] = '{1'b0, 2'b01, 4'b0110, 1'b0, 2, 1, 2, 1, 14, 10, 0};
      tbl[11] = '{1'b0, 2'b01, 4'b0000, 1'b1, 3, 1, 2, 1, 14, 10, 0};
      tbl[12] = '{1'b0, 2'b01, 4'b0000, 1'b0, 2, 1, 2, 2, 14, 10, 0};
      tbl[13] = '{1'b0, 2'b01, 4'b0010, 1'b0, 2, 1, 2, 2, 14, 10, 0};
      tbl[14] = '{1'b0, 2'b01, 4'b0000, 1'b1, 3, 1, 2, 2, 14, 10, 0};
      tbl[15] = '{1'b0, 2'b01, 4'b0000, 1'b0, 2, 1, 1, 2, 14, 10, 0};
      tbl[16] = '{1'b1, 2'b01, 4'b0000, 1'b0, 0, 0, 1, 2, 14, 10, 0};
      tbl[17] = '{1'b0, 2'b00, 4'b0000, 1'b0, 0, 0, 1, 2, 14, 10, 0};
      tbl[18] = '{1'b1, 2'b00, 4'b0000, 1'b0, 0, 0, 1, 2, 14, 10, 0};
      tbl[19] = '{1'b0, 2'b11, 4'b0000, 1'b0, 0, 0, 1, 2, 14, 10, 0};
      tbl[20] = '{1'b1, 2'b11, 4'b0000, 1'b0, 1, 3, 1, 2, 14, 10, 0};
      tbl[21] = '{1'b0, 2'b01, 4'b0000, 1'b0, 2, 3, 1, 1, 38, 28, 0};

      // Reset state.
      #(4 * halfClk + 2);
      chk("rst state", int'(o_State), 0);
      chk("rst level", int'(o_Level), 0);
      chkPos("rst player", 1, 1);
      chk("rst goal x", int'(o_GoalPos_X), 0);
      chk("rst goal y", int'(o_GoalPos_Y), 0);
      chk("rst win", int'(o_fWin), 0);
`ifdef MOVE_COUNT_EN
      chk("rst movecnt", int'(o_MoveCnt), 0);
`endif
      @(negedge i_Clk);
      i_Rst = 1'b1;
      tick();

      for (int i = 0; i < 22; i++) begin
         i_Start     = tbl[i].start;
         i_LevelSel  = tbl[i].sel;
         i_Btn       = tbl[i].btn;
         i_fDrawDone = tbl[i].dd;
         tick();
         chk($sformatf("row%0d state", i), int'(o_State), tbl[i].st);
         chk($sformatf("row%0d level", i), int'(o_Level), tbl[i].lvl);
         chk($sformatf("row%0d px", i), int'(o_PlayerPos_X), tbl[i].px);
         chk($sformatf("row%0d py", i), int'(o_PlayerPos_Y), tbl[i].py);
         chk($sformatf("row%0d gx", i), int'(o_GoalPos_X), tbl[i].gx);
         chk($sformatf("row%0d gy", i), int'(o_GoalPos_Y), tbl[i].gy);
         chk($sformatf("row%0d win", i), int'(o_fWin), tbl[i].win);
      end

      // Wall above (1,1); a press during CHECK must be dropped.
      i_Map[1198] = 1'b1;
      newGame(2'b01);
      chkPos("wall start", 1, 1);
      i_Btn = 4'b1000;
      tick();
      i_Btn = 4'b0000;
      i_fDrawDone = 1'b1;
      tick();
      chk("wall check", int'(o_State), 3);
      i_fDrawDone = 1'b0;
      i_Btn = 4'b0001;
      tick();
      chk("wall back to play", int'(o_State), 2);
      chkPos("wall blocked", 1, 1);
      i_Btn = 4'b0000;
      i_fDrawDone = 1'b1;
      tick();
      i_fDrawDone = 1'b0;
      chk("pending cleared", int'(o_State), 2);
      i_Map[1198] = 1'b0;
      tick();

      // Left edge underflow on easy level.
      move(4'b0010);
      for (int i = 0; i < 4; i++) move(4'b0100);
      chkPos("reach (0,5)", 0, 5);
      move(4'b0010);
      chkPos("left underflow", 0, 5);
      chk("underflow state", int'(o_State), 2);
`ifdef MOVE_COUNT_EN
      chk("movecnt easy", int'(o_MoveCnt), 5);
`endif

      // Right edge on hard level.
      newGame(2'b11);
`ifdef MOVE_COUNT_EN
      chk("movecnt load clear", int'(o_MoveCnt), 0);
`endif
      for (int i = 0; i < 38; i++) move(4'b0001);
      for (int i = 0; i < 4; i++) move(4'b0100);
      chkPos("reach (39,5)", 39, 5);
      move(4'b0001);
      chkPos("right edge", 39, 5);

      // Mid level: walk to (29,22), step onto the goal.
      newGame(2'b10);
      chk("mid goal x", int'(o_GoalPos_X), 30);
      chk("mid goal y", int'(o_GoalPos_Y), 22);
      for (int i = 0; i < 28; i++) move(4'b0001);
      for (int i = 0; i < 21; i++) move(4'b0100);
      chkPos("reach (29,22)", 29, 22);
      i_Btn = 4'b0001;
      tick();
      i_Btn = 4'b0000;
      i_fDrawDone = 1'b1;
      tick();
      i_fDrawDone = 1'b0;
      chk("goal check", int'(o_State), 3);
      tick();
      chk("win state", int'(o_State), 4);
      chk("win flag", int'(o_fWin), 1);
      chkPos("win pos", 30, 22);
      move(4'b1000);
      chk("win hold state", int'(o_State), 4);
      chkPos("win hold pos", 30, 22);
`ifdef MOVE_COUNT_EN
      chk("movecnt win", int'(o_MoveCnt), 50);
`endif
      i_Start = 1'b1;
      tick();
      i_Start = 1'b0;
      chk("win exit state", int'(o_State), 0);
      chk("win exit level", int'(o_Level), 0);
      chk("win exit flag", int'(o_fWin), 0);
      tick();

      // Reset asserted during CHECK discards the move.
      i_LevelSel = 2'b01;
      pressStart();
      i_Btn = 4'b0001;
      tick();
      i_Btn = 4'b0000;
      i_fDrawDone = 1'b1;
      tick();
      i_fDrawDone = 1'b0;
      chk("pre-reset check", int'(o_State), 3);
      #2;
      i_Rst = 1'b0;
      #1;
      chk("async rst state", int'(o_State), 0);
      chk("async rst level", int'(o_Level), 0);
      tick();
      chkPos("move discarded", 1, 1);
      @(negedge i_Clk);
      i_Rst = 1'b1;
      tick();
      chk("post-reset idle", int'(o_State), 0);
      chkPos("post-reset pos", 1, 1);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
      $finish;
   end

endmodule

// File: doc/maze_ctrl.md
MAZE_CTRL -- requirements
Module: maze_ctrl

Interface
REQ-001 SHALL have parameters: START_X, 6'd1, player start column; START_Y, 5'd1, player start row.
REQ-002 SHALL have ports, in this order:
- i_Clk  in  1  system clock.
- i_Rst  in  1  asynchronous active-low reset.
- i_Start  in  1  start/restart button, active-high, synchronous to i_Clk.
- i_LevelSel  in  2  01 easy, 10 mid, 11 hard, 00 invalid.
- i_Btn  in  4  [3] up, [2] down, [1] left, [0] right; active-high.
- i_fDrawDone  in  1  one-cycle end-of-visible-frame pulse from the draw block.
- i_Map  in  1200  wall map; cell (x,y) is wall when i_Map[1199-(y*40+x)]=1.
- o_Level  out  2  active level; 00 when idle.
- o_PlayerPos_X / o_PlayerPos_Y  out  6/5  player cell.
- o_GoalPos_X / o_GoalPos_Y  out  6/5  goal cell.
- o_fWin  out  1  high while in WIN.
- o_State  out  3  IDLE=0, LOAD=1, PLAY=2, CHECK=3, WIN=4.

Function
REQ-003 SHALL set grid size (W,H) from o_Level: 01 -> 16x12, 10 -> 32x24, 11 -> 40x30.
REQ-004 SHALL rising-edge detect i_Start and each i_Btn bit with one registered previous-value stage; "press" means current=1 and previous=0.
REQ-005 IDLE: on an i_Start press with i_LevelSel!=00, SHALL latch i_LevelSel into o_Level and go to LOAD; SHALL stay in IDLE when i_LevelSel=00.
REQ-006 LOAD (one cycle):
- SHALL load the player to (START_X, START_Y) and the goal to (W-2, H-2).
- SHALL clear pending and go to PLAY.
REQ-007 PLAY, pending empty: a button press SHALL latch a direction into pending.
- Priority when several presses occur in one cycle: up > down > left > right.
- Presses while pending is full SHALL be ignored.
REQ-008 PLAY: when i_fDrawDone=1 and pending is full, SHALL go to CHECK next cycle; with pending empty, i_fDrawDone SHALL have no effect.
REQ-009 CHECK (exactly one cycle): SHALL compute target = player +/- 1 in the pending direction.
- Update the player only if the target is in bounds (0..W-1, 0..H-1; underflow below 0 counts as out of bounds) and is not a wall.
- Clear pending; presses during CHECK SHALL be dropped.
REQ-010 Position latency: the new position SHALL be visible on the second rising edge after the i_fDrawDone cycle; at most one move SHALL occur per frame.
REQ-011 After CHECK: go to WIN if the updated player equals the goal, otherwise go to PLAY.
REQ-012 WIN: o_fWin=1 and position SHALL be held; an i_Start press SHALL go to IDLE and clear o_Level to 00.
REQ-013 An i_Start press in PLAY SHALL go to IDLE, abandoning the game; it SHALL be ignored in LOAD and CHECK.
REQ-014 i_LevelSel changes outside IDLE SHALL be ignored.

Reset
REQ-015 i_Rst=0 SHALL asynchronously force:
- state IDLE, o_Level=00, pending empty;
- player=(START_X, START_Y), goal=(0,0), o_fWin=0;
- edge-detect history=0.
REQ-016 Reset asserted mid-CHECK SHALL discard the move; the first press after reset release SHALL be detected only on a 0->1 transition.

Configuration
REQ-017 With MOVE_COUNT_EN defined, SHALL add output o_MoveCnt (10 bits).
- Cleared in reset and LOAD.
- Incremented on each accepted move in CHECK, saturating at 1023.
- Held in WIN.
Without the macro, the port and counter SHALL NOT exist.

Verification
REQ-018 Reset, LevelSel=01, Start press -> LOAD one cycle, then PLAY; player=(1,1), goal=(14,10), o_Level=01.
REQ-019 PLAY on an open map, right press, then i_fDrawDone pulse at cycle N -> CHECK at N+1, player=(2,1) from N+2; a second press before the pulse -> ignored.
REQ-020 Player at (1,1) with a wall at (1,0), up press then frame pulse -> player stays (1,1), pending cleared, state PLAY.
REQ-021 Player at (0,5), left press then pulse -> no move (underflow); hard level, player at (39,5), right press -> no move.
REQ-022 Mid level, player at (29,22), right press then pulse -> player=(30,22)=goal, o_fWin=1; Start press -> IDLE, o_Level=00.
REQ-023 With MOVE_COUNT_EN: 3 accepted moves and 1 blocked move -> o_MoveCnt=3; LOAD -> 0.
